// File: rtl/i2c_master_tx.sv
// Single-byte I2C write master: START, {addr,W}, data, STOP, with an ACK check after each byte.
// go is taken only while idle (never queued); SDA is paced by the returned scl, and START/STOP hold HOLD_CYCLES clocks.
module i2c_master_tx #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       scl,
    input  logic       sda_in,
    output logic       start_cond,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    typedef enum logic [2:0] {IDLE, START, RUN, STOP_WAIT, STOP} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t      state, state_n;
    logic        scl_d;
    logic        fall, rise;
    logic [6:0]  addr_q, addr_n;
    logic [7:0]  data_q, data_n;
    logic [7:0]  addr_frame;
    logic [4:0]  bit_cnt, bit_cnt_n, cnt_inc;
    logic [3:0]  hold_cnt, hold_cnt_n;
    logic        sda_n, start_n, busy_n, done_n, nack_n;

    assign fall       = scl_d & ~scl;
    assign rise       = ~scl_d & scl;
    assign addr_frame = {addr_q, 1'b0};
    assign cnt_inc    = bit_cnt + 5'd1;

    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        data_n     = data_q;
        bit_cnt_n  = bit_cnt;
        hold_cnt_n = hold_cnt;
        sda_n      = sda_out;
        start_n    = start_cond;
        busy_n     = busy;
        done_n     = 1'b0;
        nack_n     = nack;
        case (state)
            IDLE: begin
                if (go) begin
                    addr_n     = addr;
                    data_n     = data;
                    nack_n     = 1'b0;
                    sda_n      = 1'b0;
                    busy_n     = 1'b1;
                    bit_cnt_n  = 5'd0;
                    hold_cnt_n = 4'd0;
                    state_n    = START;
                end
            end
            START: begin
                if (hold_cnt == HOLD_LAST) begin
                    start_n = 1'b1;
                    state_n = RUN;
                end else begin
                    hold_cnt_n = hold_cnt + 4'd1;
                end
            end
            RUN: begin
                // Every SDA change lands one clock after an SCL fall, so it is always made with SCL low.
                if (fall) begin
                    bit_cnt_n = cnt_inc;
                    if (bit_cnt == 5'd9 && nack) begin
                        sda_n   = 1'b0;
                        state_n = STOP_WAIT;
                    end else if (cnt_inc <= 5'd8) begin
                        sda_n = addr_frame[3'(5'd8 - cnt_inc)];
                    end else if (cnt_inc == 5'd9 || cnt_inc == 5'd18) begin
                        sda_n = 1'b1;
                    end else if (cnt_inc <= 5'd17) begin
                        sda_n = data_q[3'(5'd17 - cnt_inc)];
                    end else begin
                        sda_n   = 1'b0;
                        state_n = STOP_WAIT;
                    end
                end else if (rise && (bit_cnt == 5'd9 || bit_cnt == 5'd18)) begin
                    nack_n = sda_in;
                end
            end
            STOP_WAIT: begin
                if (rise) begin
                    start_n    = 1'b0;
                    hold_cnt_n = 4'd0;
                    state_n    = STOP;
                end
            end
            STOP: begin
                if (hold_cnt == HOLD_LAST) begin
                    sda_n   = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            scl_d      <= 1'b1;
            addr_q     <= 7'd0;
            data_q     <= 8'd0;
            bit_cnt    <= 5'd0;
            hold_cnt   <= 4'd0;
            sda_out    <= 1'b1;
            start_cond <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
        end else begin
            state      <= state_n;
            scl_d      <= scl;
            addr_q     <= addr_n;
            data_q     <= data_n;
            bit_cnt    <= bit_cnt_n;
            hold_cnt   <= hold_cnt_n;
            sda_out    <= sda_n;
            start_cond <= start_n;
            busy       <= busy_n;
            done       <= done_n;
            nack       <= nack_n;
        end
    end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Testbench for i2c_master_tx with a simple SCL generator and an ACKing/NACKing slave.
module tb_i2c_master_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] data = 8'd0;
    logic       scl;
    logic       sda_in;
    logic       start_cond, sda_out, busy, done, nack;

    i2c_master_tx #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .addr(addr), .data(data),
        .scl(scl), .sda_in(sda_in), .start_cond(start_cond), .sda_out(sda_out),
        .busy(busy), .done(done), .nack(nack)
    );

    always #5 clk = ~clk;

    // SCL generator: high while start_cond=0, otherwise toggles every 4 clocks.
    logic [1:0] div;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl <= 1'b1;
            div <= 2'd0;
        end else if (!start_cond) begin
            scl <= 1'b1;
            div <= 2'd0;
        end else if (div == 2'd3) begin
            div <= 2'd0;
            scl <= ~scl;
        end else begin
            div <= div + 2'd1;
        end
    end

    // Bus monitor, sampled on the falling clock edge.
    int         rise_tot = 0, fall_tot = 0, stop_tot = 0, viol_tot = 0;
    int         rise_base = 0, fall_base = 0, stop_base = 0, viol_base = 0;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic [63:0] rec = 64'd0;
    always @(negedge clk) begin
        scl_p <= scl;
        sda_p <= sda_out;
        if (scl === 1'b1 && scl_p === 1'b0) begin
            rise_tot <= rise_tot + 1;
            rec      <= {rec[62:0], sda_out};
        end
        if (scl === 1'b0 && scl_p === 1'b1) fall_tot <= fall_tot + 1;
        if (sda_out !== sda_p && scl === 1'b1 && scl_p === 1'b1) begin
            if (start_cond) viol_tot <= viol_tot + 1;
            else if (sda_out) stop_tot <= stop_tot + 1;
        end
    end

    // Slave pulls SDA low in the ACK slot that follows fall 9 / fall 18 when told to ACK.
    logic ack1 = 1'b0, ack2 = 1'b0;
    logic slave_low;
    assign slave_low = ((fall_tot - fall_base) == 9 && ack1) || ((fall_tot - fall_base) == 18 && ack2);
    assign sda_in    = sda_out & ~slave_low;

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic        ack1;
        logic        ack2;
        logic        exp_nack;
        int          exp_rises;
        logic [18:0] exp_bits;
    } vec_t;

    vec_t vecs[4];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic go_req(input logic [6:0] a, input logic [7:0] d, input logic k1, input logic k2);
        addr = a;
        data = d;
        go   = 1'b1;
        @(negedge clk);
        go        = 1'b0;
        fall_base = fall_tot;
        rise_base = rise_tot;
        stop_base = stop_tot;
        viol_base = viol_tot;
        ack1      = k1;
        ack2      = k2;
        chk("accept_busy", busy, 1);
        chk("accept_sda_low", sda_out, 0);
        chk("accept_nack_clear", nack, 0);
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, got, 1);
    endtask

    task automatic wait_falls(input int n);
        bit got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fall_tot - fall_base >= n) begin
                got = 1'b1;
                break;
            end
        end
        chk("fall_count_reached", got, 1);
    endtask

    // Called at the clock where done=1.
    task automatic post_checks(input vec_t v, input bit tail);
        logic [63:0] m;
        m = (64'd1 << v.exp_rises) - 64'd1;
        chk("done_nack", nack, v.exp_nack);
        chk("done_busy_low", busy, 0);
        chk("done_sda_released", sda_out, 1);
        chk("done_scl_high", scl, 1);
        chk("scl_rise_count", rise_tot - rise_base, v.exp_rises);
        chk("sda_bits_on_rises", rec & m, {45'd0, v.exp_bits});
        chk("sda_change_scl_high", viol_tot - viol_base, 0);
        if (tail) begin
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("stop_condition", stop_tot - stop_base, 1);
            repeat (4) @(negedge clk);
            chk("nack_held", nack, v.exp_nack);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{7'h50, 8'hA5, 1'b1, 1'b1, 1'b0, 19, {8'hA0, 1'b1, 8'hA5, 2'b10}};
        vecs[1] = '{7'h3C, 8'h0F, 1'b0, 1'b1, 1'b1, 10, 19'({8'h78, 2'b10})};
        vecs[2] = '{7'h7F, 8'h81, 1'b1, 1'b0, 1'b1, 19, {8'hFE, 1'b1, 8'h81, 2'b10}};
        vecs[3] = '{7'h01, 8'h00, 1'b1, 1'b1, 1'b0, 19, {8'h02, 1'b1, 8'h00, 2'b10}};

        repeat (3) @(negedge clk);
        chk("reset_sda_out", sda_out, 1);
        chk("reset_start_cond", start_cond, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_nack", nack, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // START timing: go at cycle 0, sda low at cycle 1, start_cond at cycle 5.
        go_req(vecs[0].addr, vecs[0].data, vecs[0].ack1, vecs[0].ack2);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk("start_hold_no_start_cond", start_cond, 0);
        end
        @(negedge clk);
        chk("start_cond_at_cycle5", start_cond, 1);
        chk("start_scl_still_high", scl, 1);
        wait_done("timing");
        post_checks(vecs[0], 1'b1);

        for (int i = 0; i < 4; i++) begin
            go_req(vecs[i].addr, vecs[i].data, vecs[i].ack1, vecs[i].ack2);
            wait_done("table");
            post_checks(vecs[i], 1'b1);
        end

        // go mid-transfer is ignored; go on the done cycle starts the next transfer.
        go_req(vecs[0].addr, vecs[0].data, vecs[0].ack1, vecs[0].ack2);
        wait_falls(5);
        addr = vecs[3].addr;
        data = vecs[3].data;
        go   = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("midgo_still_busy", busy, 1);
        wait_done("midgo");
        post_checks(vecs[0], 1'b0);
        go_req(vecs[2].addr, vecs[2].data, vecs[2].ack1, vecs[2].ack2);
        wait_done("b2b");
        post_checks(vecs[2], 1'b1);

        // Reset in the middle of the data byte, then a clean transfer.
        go_req(vecs[0].addr, vecs[0].data, vecs[0].ack1, vecs[0].ack2);
        wait_falls(12);
        rst_n = 1'b0;
        #1;
        chk("midrst_sda_out", sda_out, 1);
        chk("midrst_start_cond", start_cond, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_nack", nack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go_req(vecs[3].addr, vecs[3].data, vecs[3].ack1, vecs[3].ack2);
        wait_done("after_reset");
        post_checks(vecs[3], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
